demux_rr_ctrl: RTL
==================

DEMUX_RR_CTRL -- requirements
Module: demux_rr_ctrl

Interface
REQ-001 Parameter W, default 8: data width in bits.
REQ-002 Parameter BURST, default 4: number of words sent to one channel before rotating (BURST >= 1).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 din  input  W  input data word.
REQ-007 din_valid  input  1  din holds a valid word.
REQ-008 din_last  input  1  the current word ends the burst early.
REQ-009 din_ready  output  1  the block accepts din this cycle.
REQ-010 en_mask  input  4  per-channel enable; bit i enables channel i.
REQ-011 dout  output  W  registered data, shared by all channels.
REQ-012 dout_valid  output  4  one-hot; bit i means dout is offered to channel i.
REQ-013 dout_ready  input  4  per-channel sink ready.
REQ-014 sel  output  2  channel that the next accepted word is scheduled to.

Function
REQ-015 Internal state SHALL be:
- output register: dout, vld, ch[1:0];
- schedule pointer: sel;
- burst counter: cnt, 0..BURST-1.
REQ-016 dout_valid[i] SHALL equal vld && (ch == i); at most one bit is set.
REQ-017 A drain SHALL occur when vld && dout_ready[ch].
REQ-018 din_ready SHALL equal en_mask[sel] && (!vld || dout_ready[ch]). This is combinational with no added bubble, so sustained throughput is 1 word/cycle.
REQ-019 On accept (din_valid && din_ready), at the next edge:
- dout <= din;
- ch <= sel;
- vld <= 1;
- latency from din to dout is 1 cycle.
REQ-020 A drain with no simultaneous accept SHALL clear vld. A simultaneous drain and accept SHALL load the new word with vld held at 1.
REQ-021 On accept with cnt == BURST-1 or din_last = 1: cnt <= 0 and sel <= next(sel). Otherwise, on accept, cnt <= cnt+1.
REQ-022 next(sel) SHALL be the first enabled channel after sel in circular order sel+1, sel+2, sel+3, sel. Channel 3 wraps to channel 0.
REQ-023 If en_mask[sel] = 0 and en_mask != 0:
- no word is accepted;
- at the next edge, sel <= next(sel) and cnt <= 0;
- a word already held in the output register is still offered to its channel ch.
REQ-024 If en_mask == 0:
- din_ready SHALL be 0;
- sel and cnt SHALL hold;
- any held word SHALL still drain.
REQ-025 dout, ch and vld SHALL hold while vld = 1 and dout_ready[ch] = 0.
REQ-026 din_last with BURST = 1 SHALL have the same effect as a normal burst end; it SHALL NOT cause a double advance.

Reset
REQ-027 While rst = 1 at a clock edge: dout = 0, vld = 0, ch = 0, sel = 0, cnt = 0. Consequently dout_valid = 4'b0000.
REQ-028 Reset mid-burst SHALL discard the held word and restart scheduling at channel 0.
REQ-029 din_ready SHALL be evaluated from the reset state in the first cycle after reset.

Configuration
REQ-030 The macro DEMUX_RR_SKIP_BUSY_EN SHALL control busy-channel skipping at burst end.
REQ-031 With DEMUX_RR_SKIP_BUSY_EN defined:
- the advance of REQ-021 SHALL pick the first channel after sel that is enabled and has dout_ready = 1 in that cycle;
- if no channel qualifies, the block SHALL fall back to REQ-022.
REQ-032 With DEMUX_RR_SKIP_BUSY_EN undefined, the block SHALL use strict REQ-022 rotation, regardless of dout_ready.

Verification
REQ-033 BURST=4, en_mask=4'hF, all ready, 16 consecutive words 0x00..0x0F -> dout_valid cycles 0001 x4, 0010 x4, 0100 x4, 1000 x4, one cycle after each accept; sel returns to 0.
REQ-034 Word 0xA5 on channel 0, dout_ready[0]=0 for 3 cycles -> dout=0xA5 and dout_valid=0001 held; din_ready=0 for 3 cycles; drains on cycle 4.
REQ-035 en_mask=4'b0101, BURST=2, 8 words -> channels 0,0,2,2,0,0,2,2; channels 1 and 3 are never asserted.
REQ-036 din_last=1 on the 2nd word of channel 0 (BURST=4) -> the 3rd word goes to channel 1 and cnt restarts.
REQ-037 rst=1 asserted after 2 words of a burst on channel 1 -> next cycle dout_valid=0000, sel=0, dout=0; the next word goes to channel 0.
REQ-038 With DEMUX_RR_SKIP_BUSY_EN defined, burst end on channel 0 with dout_ready=4'b1001 -> sel=3. Undefined -> sel=1.

Source files
------------

// File: rtl/demux_rr_ctrl_if.sv
// Handshake bundle for demux_rr_ctrl: one input stream, four output channels.
// slave is the demux side, master is the source/sink side.
interface demux_rr_ctrl_if #(
  parameter int W = 8
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_last;
  logic         din_ready;
  logic [3:0]   en_mask;
  logic [W-1:0] dout;
  logic [3:0]   dout_valid;
  logic [3:0]   dout_ready;
  logic [1:0]   sel;

  modport slave (
    input  din,
    input  din_valid,
    input  din_last,
    input  en_mask,
    input  dout_ready,
    output din_ready,
    output dout,
    output dout_valid,
    output sel
  );

  modport master (
    output din,
    output din_valid,
    output din_last,
    output en_mask,
    output dout_ready,
    input  din_ready,
    input  dout,
    input  dout_valid,
    input  sel
  );
endinterface

// File: rtl/demux_rr_ctrl.sv
// Round-robin burst demux: one stream fanned out to four channels.
// Define DEMUX_RR_SKIP_BUSY_EN to skip busy channels at burst end.
module demux_rr_ctrl #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input logic            clk,
  input logic            rst,
  demux_rr_ctrl_if.slave bus
);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

  logic [W-1:0]  dout_q;
  logic          vld_q;
  logic [1:0]    ch_q;
  logic [1:0]    sel_q;
  logic [CW-1:0] cnt_q;

  logic       drain;
  logic       ready;
  logic       accept;
  logic       burst_end;
  logic       skip_dis;
  logic [1:0] nxt_strict;
  logic [1:0] nxt_end;

  // First channel set in m after cur, with cur itself checked last.
  function automatic logic [1:0] next_ch(
    input logic [1:0] cur,
    input logic [3:0] m
  );
    logic [1:0] r;
    logic [1:0] idx;
    logic       f;
    r = cur;
    f = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = cur + 2'(k);
      if (!f && m[idx]) begin
        r = idx;
        f = 1'b1;
      end
    end
    return r;
  endfunction

  assign drain     = vld_q && bus.dout_ready[ch_q];
  assign ready     = bus.en_mask[sel_q] && (!vld_q || bus.dout_ready[ch_q]);
  assign accept    = bus.din_valid && ready;
  assign burst_end = (cnt_q == CNT_MAX) || bus.din_last;
  assign skip_dis  = !bus.en_mask[sel_q] && (bus.en_mask != 4'b0000);

  assign nxt_strict = next_ch(sel_q, bus.en_mask);

`ifdef DEMUX_RR_SKIP_BUSY_EN
  logic [3:0] qual;
  assign qual    = bus.en_mask & bus.dout_ready;
  assign nxt_end = (qual != 4'b0000) ? next_ch(sel_q, qual) : nxt_strict;
`else
  assign nxt_end = nxt_strict;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      ch_q   <= 2'd0;
      sel_q  <= 2'd0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        dout_q <= bus.din;
        ch_q   <= sel_q;
        vld_q  <= 1'b1;
        if (burst_end) begin
          cnt_q <= '0;
          sel_q <= nxt_end;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (drain) begin
        vld_q <= 1'b0;
      end
      // accept and skip_dis never coincide: skip_dis forces ready low
      if (skip_dis) begin
        sel_q <= nxt_strict;
        cnt_q <= '0;
      end
    end
  end

  assign bus.din_ready  = ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q ? (4'b0001 << ch_q) : 4'b0000;
  assign bus.sel        = sel_q;
endmodule
